// File: rtl/board_kernel_bridge_mc.sv
// Host control bridge: 32-bit Avalon-MM slave that serves a local CSR bank and
// forwards kernel-window accesses to one of NUM_KERNELS 64-bit CRA masters.
// Also handles per-kernel IRQ masking and aggregation, a timed kernel soft
// reset, and a CRA access timeout. One host transaction is in flight at a time.
module board_kernel_bridge_mc #(
  parameter int NUM_KERNELS  = 2,
  parameter int CTRL_ADDR_W  = 14,
  parameter int CRA_ADDR_W   = 30,
  parameter int RESET_CYCLES = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [CTRL_ADDR_W-1:0]      ctrl_address,
  input  logic                        ctrl_read,
  input  logic                        ctrl_write,
  input  logic [31:0]                 ctrl_writedata,
  input  logic [3:0]                  ctrl_byteenable,
  output logic                        ctrl_waitrequest,
  output logic [31:0]                 ctrl_readdata,
  output logic                        ctrl_readdatavalid,
  output logic [CRA_ADDR_W-1:0]       kernel_cra_address,
  output logic [63:0]                 kernel_cra_writedata,
  output logic [7:0]                  kernel_cra_byteenable,
  output logic [NUM_KERNELS-1:0]      kernel_cra_read,
  output logic [NUM_KERNELS-1:0]      kernel_cra_write,
  input  logic [NUM_KERNELS-1:0]      kernel_cra_waitrequest,
  input  logic [64*NUM_KERNELS-1:0]   kernel_cra_readdata,
  input  logic [NUM_KERNELS-1:0]      kernel_cra_readdatavalid,
  input  logic [NUM_KERNELS-1:0]      kernel_irq_from_kernel_irq,
  output logic                        kernel_irq_to_host_irq,
  output logic                        kernel_reset_reset_n,
  output logic [1:0]                  acl_bsp_memorg_host0x018_mode
);

  localparam int KSEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int OFF_W  = CTRL_ADDR_W - 1 - KSEL_W;
  localparam int CSR_W  = CTRL_ADDR_W - 1;
  localparam int RCNT_W = $clog2(RESET_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT);

  localparam logic [KSEL_W:0]   NK_LIM    = (KSEL_W+1)'(NUM_KERNELS);
  localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [31:0]       VERSION   = 32'h0002_0000 | NUM_KERNELS;
  localparam logic [31:0]       ABORT_RD  = 32'hDEAD_BEEF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_RDV  = 3'd4;

  logic [2:0]             state;
  logic                   is_rd;
  logic                   half;
  logic [KSEL_W-1:0]      ksel;
  logic [TCNT_W-1:0]      tcnt;
  logic [31:0]            rdata;
  logic [NUM_KERNELS-1:0] irq_mask;
  logic [1:0]             mode;
  logic                   err_flag;
  logic [1:0]             err_k;
  logic [RCNT_W-1:0]      rcnt;
  logic                   irq_out;

  logic                   req;
  logic                   is_kern;
  logic                   k_valid;
  logic [KSEL_W-1:0]      req_k;
  logic [OFF_W-1:0]       req_w;
  logic [CSR_W-1:0]       csr_off;
  logic [31:0]            csr_rdata;
  logic [31:0]            lane;
  logic                   tmo_fire;
  logic                   bad_k;
  logic                   csr_wr;

  // Byte address of the 64-bit CRA word holding 32-bit host word w.
  function automatic logic [CRA_ADDR_W-1:0] cra_byte_addr(input logic [OFF_W-1:0] w);
    logic [CRA_ADDR_W+OFF_W+1:0] wide;
    wide = {{CRA_ADDR_W{1'b0}}, w[OFF_W-1:1], 3'b000};
    return wide[CRA_ADDR_W-1:0];
  endfunction

  assign req     = ctrl_read | ctrl_write;
  assign is_kern = ctrl_address[CTRL_ADDR_W-1];
  assign req_k   = ctrl_address[CTRL_ADDR_W-2 -: KSEL_W];
  assign req_w   = ctrl_address[OFF_W-1:0];
  assign csr_off = ctrl_address[CSR_W-1:0];
  assign k_valid = ({1'b0, req_k} < NK_LIM);
  assign lane    = kernel_cra_readdata[{ksel, half, 5'd0} +: 32];

  // Timeout check only matters while a CRA access is outstanding.
  assign tmo_fire = ((state == S_CMD) || (state == S_RESP)) && (tcnt == TMO_LAST);
  assign bad_k    = (state == S_IDLE) && req && is_kern && !k_valid;
  assign csr_wr   = (state == S_IDLE) && ctrl_write && !ctrl_read && !is_kern;

  assign ctrl_waitrequest              = (state != S_ACK);
  assign ctrl_readdatavalid            = (state == S_RDV);
  assign ctrl_readdata                 = rdata;
  assign kernel_irq_to_host_irq        = irq_out;
  assign kernel_reset_reset_n          = (rcnt == '0);
  assign acl_bsp_memorg_host0x018_mode = mode;

  // CSR read multiplexer; unmapped offsets read as zero.
  always_comb begin
    csr_rdata = '0;
    if (csr_off == CSR_W'(0))      csr_rdata = VERSION;
    else if (csr_off == CSR_W'(1)) csr_rdata = 32'(kernel_irq_from_kernel_irq);
    else if (csr_off == CSR_W'(2)) csr_rdata = 32'(irq_mask);
    else if (csr_off == CSR_W'(3)) csr_rdata = {30'd0, mode};
    else if (csr_off == CSR_W'(4)) csr_rdata = {31'd0, (rcnt != '0)};
    else if (csr_off == CSR_W'(5)) csr_rdata = {22'd0, err_k, 7'd0, err_flag};
  end

  // Per-kernel strobes come straight from state so reset drops them at once;
  // they are withheld on the timeout cycle so an abort never issues a command.
  always_comb begin
    kernel_cra_read  = '0;
    kernel_cra_write = '0;
    if ((state == S_CMD) && !tmo_fire) begin
      if (is_rd) kernel_cra_read  = NUM_KERNELS'(1) << ksel;
      else       kernel_cra_write = NUM_KERNELS'(1) << ksel;
    end
  end

  // Transaction FSM: request decode, CRA command/response, host handshake.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state                 <= S_IDLE;
      is_rd                 <= 1'b0;
      half                  <= 1'b0;
      ksel                  <= '0;
      tcnt                  <= '0;
      rdata                 <= '0;
      kernel_cra_address    <= '0;
      kernel_cra_writedata  <= '0;
      kernel_cra_byteenable <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            is_rd <= ctrl_read;
            if (!is_kern) begin
              if (ctrl_read) rdata <= csr_rdata;
              state <= S_ACK;
            end else if (k_valid) begin
              ksel                  <= req_k;
              half                  <= req_w[0];
              tcnt                  <= '0;
              kernel_cra_address    <= cra_byte_addr(req_w);
              kernel_cra_writedata  <= {ctrl_writedata, ctrl_writedata};
              kernel_cra_byteenable <= ctrl_read ? 8'hFF :
                                       (req_w[0] ? {ctrl_byteenable, 4'h0} : {4'h0, ctrl_byteenable});
              state                 <= S_CMD;
            end else begin
              rdata <= ABORT_RD;
              state <= S_ACK;
            end
          end
        end
        S_CMD: begin
          if (tmo_fire) begin
            rdata <= ABORT_RD;
            state <= S_ACK;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (!kernel_cra_waitrequest[ksel]) state <= is_rd ? S_RESP : S_ACK;
          end
        end
        S_RESP: begin
          if (tmo_fire) begin
            rdata <= ABORT_RD;
            state <= S_ACK;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (kernel_cra_readdatavalid[ksel]) begin
              rdata <= lane;
              state <= S_ACK;
            end
          end
        end
        S_ACK:   state <= is_rd ? S_RDV : S_IDLE;
        S_RDV:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // CSR state: IRQ mask, memory mode, sticky error, soft-reset counter, IRQ output.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irq_mask <= '0;
      mode     <= 2'd0;
      err_flag <= 1'b0;
      err_k    <= 2'd0;
      rcnt     <= RCNT_W'(RESET_CYCLES);
      irq_out  <= 1'b0;
    end else begin
      irq_out <= |(kernel_irq_from_kernel_irq & irq_mask);
      if (csr_wr && (csr_off == CSR_W'(2)) && ctrl_byteenable[0])
        irq_mask <= ctrl_writedata[NUM_KERNELS-1:0];
      if (csr_wr && (csr_off == CSR_W'(3)) && ctrl_byteenable[0])
        mode <= ctrl_writedata[1:0];
      if (tmo_fire || bad_k) begin
        err_flag <= 1'b1;
        err_k    <= bad_k ? 2'(req_k) : 2'(ksel);
      end else if (csr_wr && (csr_off == CSR_W'(5)) && ctrl_byteenable[0] && ctrl_writedata[0]) begin
        err_flag <= 1'b0;
      end
      if (csr_wr && (csr_off == CSR_W'(4)))
        rcnt <= RCNT_W'(RESET_CYCLES);
      else if (rcnt != '0)
        rcnt <= rcnt - 1'b1;
    end
  end

endmodule
